// File: rtl/micro_sched_v.sv
// Round-robin scheduler that hands one of four requesters' codes to a micro_v
// datapath, waits SETTLE_CYC cycles, then returns the sampled result with an ack.
module micro_sched_v #(
  parameter int SETTLE_CYC = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [3:0]  i_req,
  input  logic [15:0] i_code,
  input  logic        i_m_A,
  input  logic        i_m_L,
  input  logic        i_m_B,
  output logic [3:0]  o_ack,
  output logic [2:0]  o_res,
  output logic [1:0]  o_gnt_id,
  output logic        o_busy,
  output logic [7:0]  o_txn_cnt,
  output logic        o_m_en,
  output logic [3:0]  o_m_code
);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  localparam logic [3:0] LAST = 4'(SETTLE_CYC - 1);

  state_t     state;
  logic [3:0] cnt;
  logic [1:0] rr_ptr;
  logic       pick_vld;
  logic [1:0] pick;
  logic [1:0] cand;

  // Search upward from rr_ptr+1; the last-served requester ends up last in line.
  always_comb begin
    pick_vld = 1'b0;
    pick     = rr_ptr;
    cand     = rr_ptr;
    for (int k = 1; k <= 4; k++) begin
      cand = rr_ptr + 2'(k);
      if (!pick_vld && i_req[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rr_ptr    <= 2'd3;
      o_ack     <= '0;
      o_res     <= '0;
      o_gnt_id  <= '0;
      o_busy    <= 1'b0;
      o_txn_cnt <= '0;
      o_m_en    <= 1'b0;
      o_m_code  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            o_gnt_id <= pick;
            o_m_code <= i_code[{pick, 2'b00} +: 4];
            o_m_en   <= 1'b1;
            o_busy   <= 1'b1;
            cnt      <= '0;
            state    <= DRIVE;
          end
        end
        DRIVE: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST) begin
            o_res  <= {i_m_A, i_m_L, i_m_B};
            o_ack  <= 4'b0001 << o_gnt_id;
            o_m_en <= 1'b0;
            state  <= RESP;
          end
        end
        RESP: begin
          o_ack     <= '0;
          o_txn_cnt <= o_txn_cnt + 8'd1;
          rr_ptr    <= o_gnt_id;
          o_busy    <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_micro_sched_v.sv
// Directed bench for micro_sched_v: per-cycle vector table plus hand sequences
// for contention, mid-transaction reset, counter wrap and SETTLE_CYC extremes.
module tb_micro_sched_v;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0, req1 = '0, req15 = '0;
  logic [15:0] code = '0;
  logic        m_a = 1'b0, m_l = 1'b0, m_b = 1'b0;

  logic [3:0] ack, ack1, ack15;
  logic [2:0] res, res1, res15;
  logic [1:0] gnt, gnt1, gnt15;
  logic       busy, busy1, busy15;
  logic [7:0] txn, txn1, txn15;
  logic       men, men1, men15;
  logic [3:0] mcode, mcode1, mcode15;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  micro_sched_v #(.SETTLE_CYC(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_code(code),
    .i_m_A(m_a), .i_m_L(m_l), .i_m_B(m_b),
    .o_ack(ack), .o_res(res), .o_gnt_id(gnt), .o_busy(busy),
    .o_txn_cnt(txn), .o_m_en(men), .o_m_code(mcode));

  micro_sched_v #(.SETTLE_CYC(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req1), .i_code(code),
    .i_m_A(m_a), .i_m_L(m_l), .i_m_B(m_b),
    .o_ack(ack1), .o_res(res1), .o_gnt_id(gnt1), .o_busy(busy1),
    .o_txn_cnt(txn1), .o_m_en(men1), .o_m_code(mcode1));

  micro_sched_v #(.SETTLE_CYC(15)) dut15 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req15), .i_code(code),
    .i_m_A(m_a), .i_m_L(m_l), .i_m_B(m_b),
    .o_ack(ack15), .o_res(res15), .o_gnt_id(gnt15), .o_busy(busy15),
    .o_txn_cnt(txn15), .o_m_en(men15), .o_m_code(mcode15));

  typedef struct {
    logic [3:0]  req;
    logic [15:0] code;
    logic [2:0]  m;
    logic [3:0]  ack;
    logic [2:0]  res;
    logic [1:0]  gnt;
    logic        busy;
    logic        men;
    logic [3:0]  mcode;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int acks, last_t, n, t;
    int order[5];
    order = '{0, 1, 2, 3, 0};

    // Inputs applied, then outputs expected after the following rising edge.
    tbl[0]  = '{4'b0001, 16'h0003, 3'b100, 4'b0000, 3'd0, 2'd0, 1'b1, 1'b1, 4'h3, 8'd0};
    tbl[1]  = '{4'b0001, 16'h0003, 3'b100, 4'b0000, 3'd0, 2'd0, 1'b1, 1'b1, 4'h3, 8'd0};
    tbl[2]  = '{4'b0001, 16'h0003, 3'b100, 4'b0001, 3'd4, 2'd0, 1'b1, 1'b0, 4'h3, 8'd0};
    tbl[3]  = '{4'b0000, 16'h0003, 3'b100, 4'b0000, 3'd4, 2'd0, 1'b0, 1'b0, 4'h3, 8'd1};
    tbl[4]  = '{4'b0010, 16'h0050, 3'b011, 4'b0000, 3'd4, 2'd1, 1'b1, 1'b1, 4'h5, 8'd1};
    tbl[5]  = '{4'b0010, 16'h00F0, 3'b011, 4'b0000, 3'd4, 2'd1, 1'b1, 1'b1, 4'h5, 8'd1};
    tbl[6]  = '{4'b0010, 16'h00F0, 3'b011, 4'b0010, 3'd3, 2'd1, 1'b1, 1'b0, 4'h5, 8'd1};
    tbl[7]  = '{4'b0000, 16'h0000, 3'b011, 4'b0000, 3'd3, 2'd1, 1'b0, 1'b0, 4'h5, 8'd2};
    tbl[8]  = '{4'b0100, 16'h0900, 3'b010, 4'b0000, 3'd3, 2'd2, 1'b1, 1'b1, 4'h9, 8'd2};
    tbl[9]  = '{4'b0100, 16'h0900, 3'b010, 4'b0000, 3'd3, 2'd2, 1'b1, 1'b1, 4'h9, 8'd2};
    tbl[10] = '{4'b0100, 16'h0900, 3'b010, 4'b0100, 3'd2, 2'd2, 1'b1, 1'b0, 4'h9, 8'd2};
    tbl[11] = '{4'b0101, 16'h0907, 3'b010, 4'b0000, 3'd2, 2'd2, 1'b0, 1'b0, 4'h9, 8'd3};
    tbl[12] = '{4'b0101, 16'h0907, 3'b001, 4'b0000, 3'd2, 2'd0, 1'b1, 1'b1, 4'h7, 8'd3};
    tbl[13] = '{4'b0101, 16'h0907, 3'b001, 4'b0000, 3'd2, 2'd0, 1'b1, 1'b1, 4'h7, 8'd3};
    tbl[14] = '{4'b0101, 16'h0907, 3'b001, 4'b0001, 3'd1, 2'd0, 1'b1, 1'b0, 4'h7, 8'd3};
    tbl[15] = '{4'b0100, 16'h0900, 3'b001, 4'b0000, 3'd1, 2'd0, 1'b0, 1'b0, 4'h7, 8'd4};
    tbl[16] = '{4'b0100, 16'h0900, 3'b001, 4'b0000, 3'd1, 2'd2, 1'b1, 1'b1, 4'h9, 8'd4};

    #1;
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_men", men, 0);
    chk("rst_txn", txn, 0);
    chk("rst_mcode", mcode, 0);
    do_reset();

    for (int i = 0; i < 17; i++) begin
      req = tbl[i].req;
      code = tbl[i].code;
      {m_a, m_l, m_b} = tbl[i].m;
      tick();
      chk($sformatf("v%0d_ack", i), ack, tbl[i].ack);
      chk($sformatf("v%0d_res", i), res, tbl[i].res);
      chk($sformatf("v%0d_gnt", i), gnt, tbl[i].gnt);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("v%0d_men", i), men, tbl[i].men);
      chk($sformatf("v%0d_mcode", i), mcode, tbl[i].mcode);
      chk($sformatf("v%0d_txn", i), txn, tbl[i].cnt);
    end

    // Contention: all four held; acks at edges 3,7,11,15,19 in order 0,1,2,3,0.
    req = '0;
    do_reset();
    req = 4'b1111;
    code = 16'h4321;
    acks = 0;
    last_t = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (ack != 0) begin
        chk("cont_onehot", int'($onehot(ack)), 1);
        if (acks < 5) chk($sformatf("cont_order%0d", acks), ack, 1 << order[acks]);
        if (acks == 0) chk("cont_first_edge", k, 3);
        else chk("cont_spacing", k - last_t, 4);
        last_t = k;
        acks++;
      end
    end
    chk("cont_acks", acks, 5);

    // Mid-transaction reset in the second DRIVE cycle.
    req = '0;
    do_reset();
    req = 4'b0001;
    code = 16'h0003;
    {m_a, m_l, m_b} = 3'b110;
    tick();
    tick();
    chk("mid_men_before", men, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_ack", ack, 0);
    chk("mid_busy", busy, 0);
    chk("mid_men", men, 0);
    chk("mid_mcode", mcode, 0);
    chk("mid_gnt", gnt, 0);
    chk("mid_res", res, 0);
    tick();
    chk("mid_ack_held", ack, 0);
    #2 rst_n = 1'b1;
    n = 0;
    while (ack == 0 && n < 10) begin
      tick();
      n++;
    end
    chk("mid_relat", n, 3);
    chk("mid_res_after", res, 6);
    chk("mid_txn_after", txn, 0);

    // Transaction counter wraps after 256 completions.
    req = '0;
    do_reset();
    req = 4'b0001;
    acks = 0;
    t = 0;
    while (acks < 256 && t < 1100) begin
      tick();
      t++;
      if (ack != 0) begin
        acks++;
        if (acks == 256) chk("wrap_pre", txn, 255);
      end
    end
    chk("wrap_acks", acks, 256);
    tick();
    chk("wrap_cnt", txn, 0);
    req = '0;

    // Latency counted inclusively from the sampling edge: SETTLE_CYC+1 edges.
    do_reset();
    code = 16'h000A;
    {m_a, m_l, m_b} = 3'b101;
    req1 = 4'b0001;
    n = 0;
    while (ack1 == 0 && n < 10) begin
      tick();
      n++;
    end
    chk("lat_s1", n, 2);
    chk("lat_s1_res", res1, 5);
    req1 = '0;
    req15 = 4'b0001;
    n = 0;
    while (ack15 == 0 && n < 40) begin
      tick();
      n++;
      if (n == 10) chk("s15_mcode_mid", mcode15, 4'hA);
    end
    chk("lat_s15", n, 16);
    chk("lat_s15_res", res15, 5);
    req15 = '0;
    tick();
    chk("s15_txn", txn15, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
